// File: rtl/mult_pipe_cell.sv
// mult_pipe_cell: two-stage pipelined DATA_W x DATA_W multiplier with valid/ready
// handshake. S1 captures four HALF_W x HALF_W partial products plus sign
// corrections; S2 sums them into the full 2*DATA_W product.
// Optional accumulator enabled by defining MULT_PIPE_CELL_ACC_EN.
module mult_pipe_cell #(
  parameter int DATA_W = 32,
  parameter int HALF_W = 16,
  parameter int TAG_W  = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  input  logic              src1_signed,
  input  logic              src2_signed,
  input  logic [TAG_W-1:0]  in_tag,
`ifdef MULT_PIPE_CELL_ACC_EN
  input  logic              acc_en,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] res_lo,
  output logic [DATA_W-1:0] res_hi,
  output logic [TAG_W-1:0]  out_tag
);

  localparam int PROD_W = 2 * DATA_W;

  // Partial products only line up when the operand splits into two halves.
  if (DATA_W != 2 * HALF_W) begin : g_bad_cfg
    $error("mult_pipe_cell: DATA_W must equal 2*HALF_W");
  end

  logic [HALF_W-1:0] a_lo, a_hi, b_lo, b_hi;
  logic              adv1, adv2, out_fire;

  logic              s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0] ll_q, ll_d, lh_q, lh_d, hl_q, hl_d, hh_q, hh_d;
  logic [DATA_W-1:0] corr_a_q, corr_a_d, corr_b_q, corr_b_d;
  logic [TAG_W-1:0]  tag1_q, tag1_d;

  logic              s2_valid_q, s2_valid_d;
  logic [PROD_W-1:0] res_q, res_d, prod_sum;
  logic [TAG_W-1:0]  out_tag_q, out_tag_d;

`ifdef MULT_PIPE_CELL_ACC_EN
  logic              acc_en1_q, acc_en1_d;
  logic [PROD_W-1:0] acc_q, acc_d, acc_base;
`endif

  assign a_lo = src1[HALF_W-1:0];
  assign a_hi = src1[DATA_W-1:HALF_W];
  assign b_lo = src2[HALF_W-1:0];
  assign b_hi = src2[DATA_W-1:HALF_W];

  assign adv2     = !s2_valid_q || out_ready;
  assign adv1     = !s1_valid_q || adv2;
  assign in_ready = adv1;
  assign out_fire = s2_valid_q && out_ready;

  assign out_valid = s2_valid_q;
  assign res_lo    = res_q[DATA_W-1:0];
  assign res_hi    = res_q[PROD_W-1:DATA_W];
  assign out_tag   = out_tag_q;

  // S1 next state: capture partial products and sign corrections on an input transfer.
  always_comb begin
    s1_valid_d = s1_valid_q;
    ll_d       = ll_q;
    lh_d       = lh_q;
    hl_d       = hl_q;
    hh_d       = hh_q;
    corr_a_d   = corr_a_q;
    corr_b_d   = corr_b_q;
    tag1_d     = tag1_q;
`ifdef MULT_PIPE_CELL_ACC_EN
    acc_en1_d  = acc_en1_q;
`endif
    if (flush) begin
      s1_valid_d = 1'b0;
    end else if (adv1) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        ll_d     = DATA_W'(a_lo) * DATA_W'(b_lo);
        lh_d     = DATA_W'(a_lo) * DATA_W'(b_hi);
        hl_d     = DATA_W'(a_hi) * DATA_W'(b_lo);
        hh_d     = DATA_W'(a_hi) * DATA_W'(b_hi);
        corr_a_d = (src1_signed && src1[DATA_W-1]) ? src2 : '0;
        corr_b_d = (src2_signed && src2[DATA_W-1]) ? src1 : '0;
        tag1_d   = in_tag;
`ifdef MULT_PIPE_CELL_ACC_EN
        acc_en1_d = acc_en;
`endif
      end
    end
  end

  // S2 sum: unsigned partial products minus the two's-complement corrections.
  always_comb begin
    prod_sum = {hh_q, ll_q}
             + (PROD_W'(lh_q) << HALF_W)
             + (PROD_W'(hl_q) << HALF_W)
             - {corr_a_q, {DATA_W{1'b0}}}
             - {corr_b_q, {DATA_W{1'b0}}};
`ifdef MULT_PIPE_CELL_ACC_EN
    // The result leaving this cycle becomes the accumulator, so forward it.
    acc_base = out_fire ? res_q : acc_q;
    if (acc_en1_q) begin
      prod_sum = prod_sum + acc_base;
    end
`endif
  end

  // S2 next state: move the summed product into the output register when S2 frees up.
  always_comb begin
    s2_valid_d = s2_valid_q;
    res_d      = res_q;
    out_tag_d  = out_tag_q;
`ifdef MULT_PIPE_CELL_ACC_EN
    acc_d      = acc_q;
`endif
    if (flush) begin
      s2_valid_d = 1'b0;
    end else if (adv2) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        res_d     = prod_sum;
        out_tag_d = tag1_q;
      end
    end
`ifdef MULT_PIPE_CELL_ACC_EN
    if (flush) begin
      acc_d = '0;
    end else if (out_fire) begin
      acc_d = res_q;
    end
`endif
  end

  // All pipeline state, cleared asynchronously on reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      ll_q       <= '0;
      lh_q       <= '0;
      hl_q       <= '0;
      hh_q       <= '0;
      corr_a_q   <= '0;
      corr_b_q   <= '0;
      tag1_q     <= '0;
      s2_valid_q <= 1'b0;
      res_q      <= '0;
      out_tag_q  <= '0;
`ifdef MULT_PIPE_CELL_ACC_EN
      acc_en1_q  <= 1'b0;
      acc_q      <= '0;
`endif
    end else begin
      s1_valid_q <= s1_valid_d;
      ll_q       <= ll_d;
      lh_q       <= lh_d;
      hl_q       <= hl_d;
      hh_q       <= hh_d;
      corr_a_q   <= corr_a_d;
      corr_b_q   <= corr_b_d;
      tag1_q     <= tag1_d;
      s2_valid_q <= s2_valid_d;
      res_q      <= res_d;
      out_tag_q  <= out_tag_d;
`ifdef MULT_PIPE_CELL_ACC_EN
      acc_en1_q  <= acc_en1_d;
      acc_q      <= acc_d;
`endif
    end
  end

endmodule

// File: tb/tb_mult_pipe_cell.sv
// tb_mult_pipe_cell: scoreboard bench for mult_pipe_cell. Expected products are
// pushed on each input transfer and popped on each output transfer.
// Exercises the accumulator too when MULT_PIPE_CELL_ACC_EN is defined.
module tb_mult_pipe_cell;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] src1, src2;
  logic        src1_signed, src2_signed;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] res_lo, res_hi;
  logic [4:0]  out_tag;
`ifdef MULT_PIPE_CELL_ACC_EN
  logic        acc_en;
  logic [63:0] acc_pred;
`endif

  int tests_run    = 0;
  int tests_failed = 0;
  int out_count    = 0;

  logic [63:0] exp_res_q[$];
  logic [4:0]  exp_tag_q[$];
  logic        prev_stall = 1'b0;
  logic        prev_flush = 1'b0;
  logic [63:0] held_res;
  logic [4:0]  held_tag;

  mult_pipe_cell #(.DATA_W(32), .HALF_W(16), .TAG_W(5)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .src1        (src1),
    .src2        (src2),
    .src1_signed (src1_signed),
    .src2_signed (src2_signed),
    .in_tag      (in_tag),
`ifdef MULT_PIPE_CELL_ACC_EN
    .acc_en      (acc_en),
`endif
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .res_lo      (res_lo),
    .res_hi      (res_hi),
    .out_tag     (out_tag)
  );

  always #5 clk = ~clk;

  // Reference product from sign-extended operands, independent of partial products.
  function automatic logic [63:0] refProduct(input logic [31:0] a, input logic [31:0] b,
                                             input logic sa, input logic sb);
    logic signed [65:0] ea, eb, pr;
    ea = sa ? {{34{a[31]}}, a} : {34'b0, a};
    eb = sb ? {{34{b[31]}}, b} : {34'b0, b};
    pr = ea * eb;
    return pr[63:0];
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] observed,
                             input logic [63:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input logic sa, input logic sb, input logic [4:0] tag);
    logic done;
    done        = 1'b0;
    src1        = a;
    src2        = b;
    src1_signed = sa;
    src2_signed = sb;
    in_tag      = tag;
    in_valid    = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    checkOutput("accept_timeout", 64'(done), 64'(1));
  endtask

  // Called right after the accepting edge: result must appear exactly one edge later.
  task automatic waitResult(input logic [63:0] exp_p, input logic [4:0] exp_tag);
    @(negedge clk);
    checkOutput("lat_early_valid", 64'(out_valid), 64'(0));
    @(posedge clk);
    #1;
    checkOutput("lat_valid", 64'(out_valid), 64'(1));
    checkOutput("lat_res", {res_hi, res_lo}, exp_p);
    checkOutput("lat_tag", 64'(out_tag), 64'(exp_tag));
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 50 && exp_res_q.size() > 0; i++) @(posedge clk);
    #1;
    checkOutput("drain_empty", 64'(exp_res_q.size()), 64'(0));
  endtask

  // Scoreboard monitor: occupancy-based in_ready check, stall stability, pop and push.
  always @(negedge clk) begin
    if (!reset_n) begin
      exp_res_q.delete();
      exp_tag_q.delete();
      prev_stall = 1'b0;
      prev_flush = 1'b0;
`ifdef MULT_PIPE_CELL_ACC_EN
      acc_pred = '0;
`endif
    end else begin
      checkOutput("in_ready", 64'(in_ready), 64'(!(exp_res_q.size() == 2 && !out_ready)));
      if (prev_stall && !prev_flush) begin
        checkOutput("stall_valid", 64'(out_valid), 64'(1));
        checkOutput("stall_res", {res_hi, res_lo}, held_res);
        checkOutput("stall_tag", 64'(out_tag), 64'(held_tag));
      end
      if (out_valid && out_ready) begin
        if (exp_res_q.size() == 0) begin
          checkOutput("unexpected_out", 64'(exp_res_q.size()), 64'(1));
        end else begin
          checkOutput("sb_res", {res_hi, res_lo}, exp_res_q.pop_front());
          checkOutput("sb_tag", 64'(out_tag), 64'(exp_tag_q.pop_front()));
          out_count++;
        end
      end
      if (flush) begin
        exp_res_q.delete();
        exp_tag_q.delete();
`ifdef MULT_PIPE_CELL_ACC_EN
        acc_pred = '0;
`endif
      end else if (in_valid && in_ready) begin
        logic [63:0] p;
        p = refProduct(src1, src2, src1_signed, src2_signed);
`ifdef MULT_PIPE_CELL_ACC_EN
        if (acc_en) p = p + acc_pred;
        acc_pred = p;
`endif
        exp_res_q.push_back(p);
        exp_tag_q.push_back(in_tag);
      end
      prev_stall = out_valid && !out_ready;
      held_res   = {res_hi, res_lo};
      held_tag   = out_tag;
      prev_flush = flush;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  logic stop_pattern;
  int   start_count;

  initial begin
    reset_n     = 1'b0;
    flush       = 1'b0;
    in_valid    = 1'b0;
    src1        = '0;
    src2        = '0;
    src1_signed = 1'b0;
    src2_signed = 1'b0;
    in_tag      = '0;
    out_ready   = 1'b0;
`ifdef MULT_PIPE_CELL_ACC_EN
    acc_en      = 1'b0;
`endif
    stop_pattern = 1'b0;

    // Reset state
    #12;
    checkOutput("rst_out_valid", 64'(out_valid), 64'(0));
    checkOutput("rst_res", {res_hi, res_lo}, 64'(0));
    checkOutput("rst_tag", 64'(out_tag), 64'(0));
    checkOutput("rst_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;
    reset_n   = 1'b1;
    out_ready = 1'b1;

    // Directed products with exact latency
    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 5'd5);
    waitResult(64'hFFFF_FFFE_0000_0001, 5'd5);
    applyStimulus(32'hFFFF_FFFE, 32'h0000_0003, 1'b1, 1'b1, 5'd6);
    waitResult(64'hFFFF_FFFF_FFFF_FFFA, 5'd6);
    applyStimulus(32'hFFFF_FFFE, 32'h0000_0003, 1'b0, 1'b0, 5'd7);
    waitResult(64'h0000_0002_FFFF_FFFA, 5'd7);
    applyStimulus(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 5'd8);
    waitResult(64'h4000_0000_0000_0000, 5'd8);
    applyStimulus(32'hFFFF_FFFF, 32'h0000_0005, 1'b1, 1'b0, 5'd9);
    waitResult(64'hFFFF_FFFF_FFFF_FFFB, 5'd9);
    drain();

    // Back-to-back ops under a 1,0,0,1 out_ready pattern
    start_count = out_count;
    fork
      begin
        for (int k = 0; k < 400 && !stop_pattern; k++) begin
          @(posedge clk);
          #1;
          out_ready = (k % 4 == 0) || (k % 4 == 3);
        end
      end
      begin
        for (int t = 1; t <= 8; t++) begin
          applyStimulus($urandom, $urandom, 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)), 5'(t));
        end
        stop_pattern = 1'b1;
      end
    join
    drain();
    checkOutput("stall_phase_count", 64'(out_count - start_count), 64'(8));

    // Random mixed-sign traffic at full throughput
    for (int i = 0; i < 10; i++) begin
      applyStimulus($urandom, $urandom, 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
    end
    drain();

    // Flush with two ops in flight and a third presented during the flush
    out_ready = 1'b0;
    applyStimulus(32'd11, 32'd13, 1'b0, 1'b0, 5'd20);
    applyStimulus(32'd17, 32'd19, 1'b0, 1'b0, 5'd21);
    flush    = 1'b1;
    in_valid = 1'b1;
    src1     = 32'd23;
    src2     = 32'd29;
    in_tag   = 5'd22;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    checkOutput("flush_out_valid", 64'(out_valid), 64'(0));
    out_ready = 1'b1;
    applyStimulus(32'd7, 32'd9, 1'b0, 1'b0, 5'd23);
    waitResult(64'd63, 5'd23);
    drain();

    // Asynchronous reset mid-cycle with two ops in flight
    out_ready = 1'b0;
    applyStimulus(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0, 5'd24);
    applyStimulus(32'h0F0F_0F0F, 32'h7777_7777, 1'b0, 1'b0, 5'd25);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async_rst_valid", 64'(out_valid), 64'(0));
    checkOutput("async_rst_res", {res_hi, res_lo}, 64'(0));
    checkOutput("async_rst_tag", 64'(out_tag), 64'(0));
    @(posedge clk);
    #3;
    reset_n   = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("post_rst_valid", 64'(out_valid), 64'(0));
    end

`ifdef MULT_PIPE_CELL_ACC_EN
    // Accumulate: 3*4 loads acc, 5*6 adds onto it
    @(posedge clk);
    #1;
    acc_en = 1'b0;
    applyStimulus(32'd3, 32'd4, 1'b0, 1'b0, 5'd1);
    acc_en = 1'b1;
    applyStimulus(32'd5, 32'd6, 1'b0, 1'b0, 5'd2);
    checkOutput("acc_first", {res_hi, res_lo}, 64'd12);
    @(posedge clk);
    #1;
    checkOutput("acc_second", {res_hi, res_lo}, 64'd42);
    acc_en = 1'b0;
    drain();
`endif

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
